// File: rtl/pipe_pkg.sv
// Shared pipeline package: reset/bubble constants and the IF/ID payload record.
// The IF/ID record layout is reused by the downstream ID/EX register.
package pipe_pkg;

  // Default PC after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Bubble encoding: sll $0,$0,0.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Byte increment between sequential instruction words.
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // IF/ID pipeline payload.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // Word-aligns a byte address by clearing bits [1:0].
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_if_id_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// master = fetch stage (drives the address), slave = memory (returns the word).
interface fetch_if_id_stage_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/fetch_if_id_stage_pc_reg.sv
// Program counter: PC register, next-PC selection and the +4 adder.
// Priority: rst > stall > redirect > memory wait > sequential.
module pc_reg
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Sequential successor; wraps modulo 2^32.
  always_comb begin
    pc_plus4 = pc_q + INSTR_BYTES;
  end

  // Next-PC selection; a redirect wins over a memory wait.
  always_comb begin
    pc_d = pc_q;
    if (stall) begin
      pc_d = pc_q;
    end else if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
    end else if (!imem_ready) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_plus4;
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= word_align(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_if_id_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Optional feature macro: DELAY_SLOT_EN -- when defined, the instruction fetched
// alongside a redirect (the branch delay slot) is kept instead of squashed.
module fetch_if_id_stage #(
  parameter logic [31:0] RESET_PC  = pipe_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       rst,
  fetch_if_id_stage_if.master        imem,
  input  logic                       id_stall,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic [31:0]                instr_id,
  output logic [31:0]                pc_plus4_id,
  output logic                       valid_id
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;

  pipe_pkg::if_id_t if_id_q;
  pipe_pkg::if_id_t if_id_d;
  pipe_pkg::if_id_t fetched;
  pipe_pkg::if_id_t bubble;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .stall          (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_ready     (imem.imem_ready),
    .pc             (pc),
    .pc_plus4       (pc_plus4)
  );

  // Fetch address is the current PC, no extra register stage.
  always_comb begin
    imem.imem_addr = pc;
  end

  // Candidate IF/ID payloads: the word just fetched, or a bubble at this PC.
  always_comb begin
    fetched.instr    = imem.imem_rdata;
    fetched.pc_plus4 = pc_plus4;
    fetched.valid    = 1'b1;
    bubble.instr     = NOP_INSTR;
    bubble.pc_plus4  = pc_plus4;
    bubble.valid     = 1'b0;
  end

  // IF/ID next-state selection in the same priority order as the PC.
  always_comb begin
    if_id_d = if_id_q;
    if (id_stall) begin
      if_id_d = if_id_q;
    end else if (redirect_valid) begin
`ifdef DELAY_SLOT_EN
      // Delay slot executes: keep it when the memory delivered it.
      if_id_d = imem.imem_ready ? fetched : bubble;
`else
      // Squash the sequential successor of the branch/jump.
      if_id_d = bubble;
`endif
    end else if (!imem.imem_ready) begin
      if_id_d = bubble;
    end else begin
      if_id_d = fetched;
    end
  end

  // IF/ID register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q.instr    <= NOP_INSTR;
      if_id_q.pc_plus4 <= 32'h0000_0000;
      if_id_q.valid    <= 1'b0;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign instr_id    = if_id_q.instr;
  assign pc_plus4_id = if_id_q.pc_plus4;
  assign valid_id    = if_id_q.valid;

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Self-checking bench for fetch_if_id_stage: directed vector table followed by
// randomized cycles checked against a behavioural model.
module tb_fetch_if_id_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ready;
  logic [31:0] instr_id;
  logic [31:0] pc_plus4_id;
  logic        valid_id;

  int unsigned n_cmp;
  int unsigned n_bad;

  fetch_if_id_stage_if imem_bus ();

  // Instruction memory: deterministic word per address, never the NOP encoding.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h1234_5678) | 32'h0000_0001;
  endfunction

  assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
  assign imem_bus.imem_ready = ready;

  fetch_if_id_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem_bus.master),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_id       (instr_id),
    .pc_plus4_id    (pc_plus4_id),
    .valid_id       (valid_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state: what the PC and IF/ID should hold.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pp4;
  logic        m_valid;
  logic        m_pp4_known;

  task automatic model_step();
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (rst) begin
      m_pc = RST_PC; m_instr = NOP; m_pp4 = 32'h0; m_valid = 1'b0; m_pp4_known = 1'b1;
    end else if (id_stall) begin
      // everything holds
    end else if (redirect_valid) begin
`ifdef DELAY_SLOT_EN
      if (ready) begin
        m_instr = mem_word(m_pc); m_pp4 = seq; m_valid = 1'b1; m_pp4_known = 1'b1;
      end else begin
        m_instr = NOP; m_valid = 1'b0; m_pp4_known = 1'b0;
      end
`else
      m_instr = NOP; m_valid = 1'b0; m_pp4_known = 1'b0;
`endif
      m_pc = {redirect_pc[31:2], 2'b00};
    end else if (!ready) begin
      m_instr = NOP; m_pp4 = seq; m_valid = 1'b0; m_pp4_known = 1'b1;
    end else begin
      m_instr = mem_word(m_pc); m_pp4 = seq; m_valid = 1'b1; m_pp4_known = 1'b1;
      m_pc = seq;
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: edge, model update with the inputs held over the edge, then sample.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_pp4;
    logic        exp_valid;
    logic        chk_pp4;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic rv, input logic [31:0] rp,
                              input logic rd, input logic [31:0] a, input logic [31:0] i,
                              input logic [31:0] p, input logic v, input logic cp);
    vec_t t;
    t.rst = r; t.stall = s; t.redir = rv; t.rpc = rp; t.rdy = rd;
    t.exp_addr = a; t.exp_instr = i; t.exp_pp4 = p; t.exp_valid = v; t.chk_pp4 = cp;
    return t;
  endfunction

  // Post-redirect IF/ID contents when the delay slot word was delivered.
`ifdef DELAY_SLOT_EN
  function automatic vec_t mk_redir(input logic [31:0] rp, input logic [31:0] tgt,
                                    input logic [31:0] slot_pc);
    return mk(0, 0, 1, rp, 1, tgt, mem_word(slot_pc), slot_pc + 32'd4, 1, 1);
  endfunction
`else
  function automatic vec_t mk_redir(input logic [31:0] rp, input logic [31:0] tgt,
                                    input logic [31:0] slot_pc);
    return mk(0, 0, 1, rp, 1, tgt, NOP, slot_pc + 32'd4, 0, 0);
  endfunction
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
    m_pc = 32'h0; m_instr = NOP; m_pp4 = 32'h0; m_valid = 1'b0; m_pp4_known = 1'b0;

    //                 rst stl rv  rpc            rdy addr           instr                    pp4            v  cp
    vecs.push_back(mk(1, 0, 0, 32'h0,          1, 32'h3000,      NOP,                     32'h0,         0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h3004,      mem_word(32'h3000),      32'h3004,      1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h3008,      mem_word(32'h3004),      32'h3008,      1, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h3008,      mem_word(32'h3004),      32'h3008,      1, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h3008,      mem_word(32'h3004),      32'h3008,      1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h300C,      mem_word(32'h3008),      32'h300C,      1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h3010,      mem_word(32'h300C),      32'h3010,      1, 1));
    vecs.push_back(mk_redir(32'h3043, 32'h3040, 32'h3010));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h3044,      mem_word(32'h3040),      32'h3044,      1, 1));
    vecs.push_back(mk_redir(32'h3020, 32'h3020, 32'h3044));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'h3020,      NOP,                     32'h3024,      0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'h3020,      NOP,                     32'h3024,      0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'h3020,      NOP,                     32'h3024,      0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h3024,      mem_word(32'h3020),      32'h3024,      1, 1));
    vecs.push_back(mk(0, 1, 1, 32'h3100,       1, 32'h3024,      mem_word(32'h3020),      32'h3024,      1, 1));
    vecs.push_back(mk(0, 1, 1, 32'h3100,       0, 32'h3024,      mem_word(32'h3020),      32'h3024,      1, 1));
    vecs.push_back(mk_redir(32'h3100, 32'h3100, 32'h3024));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h3104,      mem_word(32'h3100),      32'h3104,      1, 1));
    vecs.push_back(mk_redir(32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h3104));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0000_0000, mem_word(32'hFFFF_FFFC), 32'h0000_0000, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0000_0004, mem_word(32'h0),         32'h0000_0004, 1, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h0000_0004, mem_word(32'h0),         32'h0000_0004, 1, 1));
    vecs.push_back(mk(1, 1, 0, 32'h0,          1, 32'h3000,      NOP,                     32'h0,         0, 1));
    vecs.push_back(mk(1, 0, 1, 32'h5000,       0, 32'h3000,      NOP,                     32'h0,         0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 32'h3004,      mem_word(32'h3000),      32'h3004,      1, 1));

    // Directed table: inputs applied, one edge, then compare against the row.
    for (int k = 0; k < vecs.size(); k++) begin
      rst = vecs[k].rst; id_stall = vecs[k].stall; redirect_valid = vecs[k].redir;
      redirect_pc = vecs[k].rpc; ready = vecs[k].rdy;
      tick();
      check32($sformatf("vec%0d.imem_addr", k), imem_bus.imem_addr, vecs[k].exp_addr);
      check32($sformatf("vec%0d.instr_id", k), instr_id, vecs[k].exp_instr);
      check32($sformatf("vec%0d.valid_id", k), {31'h0, valid_id}, {31'h0, vecs[k].exp_valid});
      if (vecs[k].chk_pp4)
        check32($sformatf("vec%0d.pc_plus4_id", k), pc_plus4_id, vecs[k].exp_pp4);
    end

    // Randomized traffic against the model, occasional resets included.
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 99) < 2);
      id_stall       = ($urandom_range(0, 99) < 20);
      redirect_valid = ($urandom_range(0, 99) < 15);
      redirect_pc    = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                   : $urandom;
      ready          = ($urandom_range(0, 99) < 75);
      tick();
      check32($sformatf("rnd%0d.imem_addr", c), imem_bus.imem_addr, m_pc);
      check32($sformatf("rnd%0d.instr_id", c), instr_id, m_instr);
      check32($sformatf("rnd%0d.valid_id", c), {31'h0, valid_id}, {31'h0, m_valid});
      if (m_pp4_known)
        check32($sformatf("rnd%0d.pc_plus4_id", c), pc_plus4_id, m_pp4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
